// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, instruction formats and the
// operand-fetch sequencer states.
package rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_SYS,
        FMT_ILL
    } fmt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_RS1,
        ST_GAP,
        ST_RD_RS2,
        ST_OUT
    } fetch_state_t;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational RV32I decoder: instruction format, sign-extended immediate,
// which source registers the format reads, and illegal-opcode detection.
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output fmt_t        fmt,
    output logic [31:0] imm,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        illegal
);

    always_comb begin
        fmt = FMT_ILL;
        case (instr[6:0])
            OP_REG:                    fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR:  fmt = FMT_I;
            OP_STORE:                  fmt = FMT_S;
            OP_BRANCH:                 fmt = FMT_B;
            OP_LUI, OP_AUIPC:          fmt = FMT_U;
            OP_JAL:                    fmt = FMT_J;
            OP_FENCE, OP_SYSTEM:       fmt = FMT_SYS;
            default:                   fmt = FMT_ILL;
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign uses_rs1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
    assign uses_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
    assign illegal  = (fmt == FMT_ILL);

endmodule

// File: rtl/rv32i_operand_fetch.sv
// Decode-stage sequencer: latches one instruction, reads rs1/rs2 serially through
// the shared register-file port with writeback forwarding, then offers the bundle.
module rv32i_operand_fetch #(
    parameter int XLEN   = rv32i_pkg::XLEN,
    parameter int REG_AW = rv32i_pkg::REG_AW
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_if_valid,
    output logic              o_if_ready,
    input  logic [31:0]       i_if_instr,
    input  logic [XLEN-1:0]   i_if_pc,
    output logic              o_rf_rd_en,
    output logic [REG_AW-1:0] o_rf_reg_addr,
    input  logic [XLEN-1:0]   i_rf_reg_data,
    input  logic              i_rf_rd_valid,
    input  logic              i_wb_en,
    input  logic [REG_AW-1:0] i_wb_addr,
    input  logic [XLEN-1:0]   i_wb_data,
    output logic              o_ex_valid,
    input  logic              i_ex_ready,
    output logic [31:0]       o_ex_instr,
    output logic [XLEN-1:0]   o_ex_pc,
    output logic [XLEN-1:0]   o_ex_rs1,
    output logic [XLEN-1:0]   o_ex_rs2,
    output logic [XLEN-1:0]   o_ex_imm,
    output logic              o_ex_illegal
);
    import rv32i_pkg::*;

    fetch_state_t    state_reg, state_next;
    logic [31:0]     instr_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] imm_reg;
    fmt_t            fmt_reg;

    fmt_t        dec_fmt;
    logic [31:0] dec_imm;
    logic        dec_uses_rs1, dec_uses_rs2, dec_illegal;

    rv32i_imm_gen u_imm_gen (
        .instr    (i_if_instr),
        .fmt      (dec_fmt),
        .imm      (dec_imm),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2),
        .illegal  (dec_illegal)
    );

    logic                   accept;
    logic                   wb_live;
    logic [1:0]             dec_uses;
    logic [1:0]             dec_need;
    logic [1:0]             need;
    logic [1:0][REG_AW-1:0] lat_addr;
    logic [1:0][XLEN-1:0]   opnd;

    assign accept   = (state_reg == ST_IDLE) && i_if_valid;
    assign wb_live  = i_wb_en && (i_wb_addr != '0);
    assign dec_uses = {dec_uses_rs2, dec_uses_rs1};

    // Lane 0 is rs1 (instr[19:15]), lane 1 is rs2 (instr[24:20]).
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
        localparam int           FLD_LSB = (gi == 0) ? 15 : 20;
        localparam fetch_state_t RD_ST   = (gi == 0) ? ST_RD_RS1 : ST_RD_RS2;

        logic [REG_AW-1:0] dec_addr;
        logic              dec_hit, lat_hit;
        logic [XLEN-1:0]   opnd_reg;
        logic              need_reg, fwd_reg;

        assign dec_addr     = REG_AW'(i_if_instr[FLD_LSB +: 5]);
        assign lat_addr[gi] = REG_AW'(instr_reg[FLD_LSB +: 5]);
        assign dec_need[gi] = dec_uses[gi] && (dec_addr != '0);
        assign dec_hit      = wb_live && (i_wb_addr == dec_addr);
        assign lat_hit      = wb_live && (i_wb_addr == lat_addr[gi]);
        assign need[gi]     = need_reg;
        assign opnd[gi]     = opnd_reg;

        // Once a writeback has landed, the register-file result for this lane is stale.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                opnd_reg <= '0;
                need_reg <= 1'b0;
                fwd_reg  <= 1'b0;
            end else if (accept) begin
                need_reg <= dec_need[gi];
                fwd_reg  <= dec_need[gi] && dec_hit;
                opnd_reg <= (dec_need[gi] && dec_hit) ? i_wb_data : '0;
            end else if ((state_reg != ST_IDLE) && need_reg) begin
                if (lat_hit) begin
                    opnd_reg <= i_wb_data;
                    fwd_reg  <= 1'b1;
                end else if ((state_reg == RD_ST) && i_rf_rd_valid && !fwd_reg) begin
                    opnd_reg <= i_rf_reg_data;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
            instr_reg <= '0;
            pc_reg    <= '0;
            imm_reg   <= '0;
            fmt_reg   <= FMT_R;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                instr_reg <= i_if_instr;
                pc_reg    <= i_if_pc;
                imm_reg   <= XLEN'($signed(dec_imm));
                fmt_reg   <= dec_fmt;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        o_if_ready    = 1'b0;
        o_rf_rd_en    = 1'b0;
        o_rf_reg_addr = '0;
        o_ex_valid    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                o_if_ready = 1'b1;
                if (i_if_valid) begin
                    if (dec_illegal)      state_next = ST_OUT;
                    else if (dec_need[0]) state_next = ST_RD_RS1;
                    else if (dec_need[1]) state_next = ST_RD_RS2;
                    else                  state_next = ST_OUT;
                end
            end
            ST_RD_RS1: begin
                o_rf_rd_en    = 1'b1;
                o_rf_reg_addr = lat_addr[0];
                if (i_rf_rd_valid) state_next = need[1] ? ST_GAP : ST_OUT;
            end
            ST_GAP: begin
                state_next = ST_RD_RS2;
            end
            ST_RD_RS2: begin
                o_rf_rd_en    = 1'b1;
                o_rf_reg_addr = lat_addr[1];
                if (i_rf_rd_valid) state_next = ST_OUT;
            end
            ST_OUT: begin
                o_ex_valid = 1'b1;
                if (i_ex_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign o_ex_instr   = instr_reg;
    assign o_ex_pc      = pc_reg;
    assign o_ex_rs1     = opnd[0];
    assign o_ex_rs2     = opnd[1];
    assign o_ex_imm     = imm_reg;
    assign o_ex_illegal = (fmt_reg == FMT_ILL);

endmodule

// File: tb/tb_rv32i_operand_fetch.sv
// Randomized bench for rv32i_operand_fetch: a timeline model per instruction
// plus a latest-writeback-else-RF-data operand model, with a few literal cases.
module tb_rv32i_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;
    logic        rf_rd_en;
    logic [4:0]  rf_reg_addr;
    logic [31:0] rf_reg_data;
    logic        rf_rd_valid;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_instr, ex_pc, ex_rs1, ex_rs2, ex_imm;
    logic        ex_illegal;

    always #5 clk = ~clk;

    rv32i_operand_fetch dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_if_valid    (if_valid),
        .o_if_ready    (if_ready),
        .i_if_instr    (if_instr),
        .i_if_pc       (if_pc),
        .o_rf_rd_en    (rf_rd_en),
        .o_rf_reg_addr (rf_reg_addr),
        .i_rf_reg_data (rf_reg_data),
        .i_rf_rd_valid (rf_rd_valid),
        .i_wb_en       (wb_en),
        .i_wb_addr     (wb_addr),
        .i_wb_data     (wb_data),
        .o_ex_valid    (ex_valid),
        .i_ex_ready    (ex_ready),
        .o_ex_instr    (ex_instr),
        .o_ex_pc       (ex_pc),
        .o_ex_rs1      (ex_rs1),
        .o_ex_rs2      (ex_rs2),
        .o_ex_imm      (ex_imm),
        .o_ex_illegal  (ex_illegal)
    );

    typedef struct {
        bit          en;
        int          lat;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        bit          ill;
    } lit_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state for the instruction in flight.
    logic [4:0]  cur_rs1a, cur_rs2a;
    bit          cur_need1, cur_need2;
    logic [31:0] m_rs1, m_rs2;
    bit          m_f1, m_f2;
    bit          wb_random;
    bit          fwd_script;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_decode(input logic [31:0] ins, output logic [31:0] imm,
                                         output bit ill, output bit u1, output bit u2);
        logic [31:0] sh;
        imm = 32'h0;
        ill = 1'b0;
        u1  = 1'b0;
        u2  = 1'b0;
        sh  = $signed(ins) >>> 20;
        case (ins[6:0])
            7'h33: begin u1 = 1'b1; u2 = 1'b1; end
            7'h13, 7'h03, 7'h67: begin u1 = 1'b1; imm = sh; end
            7'h23: begin
                u1 = 1'b1; u2 = 1'b1;
                imm = (sh & 32'hFFFF_FFE0) | ((ins >> 7) & 32'h1F);
            end
            7'h63: begin
                u1 = 1'b1; u2 = 1'b1;
                imm = (ins[31] ? 32'hFFFF_F000 : 32'h0) | (((ins >> 7) & 32'h1) << 11)
                    | (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
            end
            7'h37, 7'h17: imm = ins & 32'hFFFF_F000;
            7'h6F: begin
                imm = (ins[31] ? 32'hFFF0_0000 : 32'h0) | (ins & 32'h000F_F000)
                    | (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
            end
            7'h0F, 7'h73: ;
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic drive_wb(input bit en, input logic [4:0] a, input logic [31:0] d);
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
        if (en && a != 5'd0) begin
            if (cur_need1 && a == cur_rs1a) begin m_rs1 = d; m_f1 = 1'b1; end
            if (cur_need2 && a == cur_rs2a) begin m_rs2 = d; m_f2 = 1'b1; end
        end
    endtask

    task automatic rand_wb();
        if (!wb_random || $urandom_range(0, 9) < 6) drive_wb(1'b0, 5'd0, 32'h0);
        else begin
            case ($urandom_range(0, 3))
                0: drive_wb(1'b1, cur_rs1a, $urandom);
                1: drive_wb(1'b1, cur_rs2a, $urandom);
                2: drive_wb(1'b1, 5'd0, $urandom);
                default: drive_wb(1'b1, 5'($urandom), $urandom);
            endcase
        end
    endtask

    task automatic do_read(input logic [4:0] a, input int l, input int which,
                           input bit use_rfd, input logic [31:0] rfd, inout int obs);
        for (int k = 1; k <= l; k++) begin
            check1("rd_en", rf_rd_en, 1'b1);
            check("rd_addr", 32'(rf_reg_addr), 32'(a));
            check1("rd_if_ready", if_ready, 1'b0);
            if (!ex_valid) obs++;
            if (k == l) begin
                rf_rd_valid = 1'b1;
                rf_reg_data = use_rfd ? rfd : $urandom;
                if (which == 1 && !m_f1) m_rs1 = rf_reg_data;
                if (which == 2 && !m_f2) m_rs2 = rf_reg_data;
            end else begin
                rf_rd_valid = 1'b0;
                rf_reg_data = $urandom;
            end
            if (fwd_script && which == 1 && k == l) drive_wb(1'b1, 5'd1, 32'h22);
            else rand_wb();
            step();
        end
        rf_rd_valid = 1'b0;
    endtask

    task automatic run_txn(input logic [31:0] instr, input logic [31:0] pc, input int l1, input int l2,
                           input int dly, input bit use_rfd, input logic [31:0] rfd1,
                           input logic [31:0] rfd2, input lit_t lit);
        logic [31:0] e_imm;
        bit          e_ill, u1, u2;
        int          obs;
        model_decode(instr, e_imm, e_ill, u1, u2);
        cur_rs1a  = instr[19:15];
        cur_rs2a  = instr[24:20];
        cur_need1 = u1 && cur_rs1a != 5'd0;
        cur_need2 = u2 && cur_rs2a != 5'd0;
        m_rs1 = 32'h0; m_rs2 = 32'h0; m_f1 = 1'b0; m_f2 = 1'b0;
        obs = 0;

        check1("idle_if_ready", if_ready, 1'b1);
        check1("idle_rd_en", rf_rd_en, 1'b0);
        check1("idle_ex_valid", ex_valid, 1'b0);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        rand_wb();
        step();
        if_valid = 1'b0;
        if_instr = $urandom;
        if_pc    = $urandom;

        if (cur_need1) do_read(cur_rs1a, l1, 1, use_rfd, rfd1, obs);
        if (cur_need1 && cur_need2) begin
            check1("gap_rd_en", rf_rd_en, 1'b0);
            check1("gap_if_ready", if_ready, 1'b0);
            if (!ex_valid) obs++;
            rand_wb();
            step();
        end
        if (cur_need2) do_read(cur_rs2a, l2, 2, use_rfd, rfd2, obs);
        if (lit.en) check("latency", 32'(obs + 1), 32'(lit.lat));

        for (int d = 0; d <= dly; d++) begin
            check1("out_ex_valid", ex_valid, 1'b1);
            check1("out_if_ready", if_ready, 1'b0);
            check1("out_rd_en", rf_rd_en, 1'b0);
            check("out_instr", ex_instr, instr);
            check("out_pc", ex_pc, pc);
            check("out_imm", ex_imm, e_imm);
            check1("out_illegal", ex_illegal, e_ill);
            check("out_rs1", ex_rs1, m_rs1);
            check("out_rs2", ex_rs2, m_rs2);
            if (lit.en && d == dly) begin
                check("lit_rs1", ex_rs1, lit.rs1);
                check("lit_rs2", ex_rs2, lit.rs2);
                check("lit_imm", ex_imm, lit.imm);
                check1("lit_illegal", ex_illegal, lit.ill);
            end
            ex_ready = (d == dly);
            if (fwd_script && d == 0) drive_wb(1'b1, 5'd2, 32'h33);
            else rand_wb();
            step();
        end
        ex_ready = 1'b0;
        drive_wb(1'b0, 5'd0, 32'h0);
        check1("post_ex_valid", ex_valid, 1'b0);
    endtask

    function automatic lit_t mk_lit(input int lat, input logic [31:0] r1, input logic [31:0] r2,
                                    input logic [31:0] imm, input bit ill);
        lit_t l;
        l.en = 1'b1; l.lat = lat; l.rs1 = r1; l.rs2 = r2; l.imm = imm; l.ill = ill;
        return l;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lit_t        nolit;
        logic [6:0]  ops [12];
        logic [31:0] r, ins;
        logic [6:0]  op;

        nolit = mk_lit(0, 32'h0, 32'h0, 32'h0, 1'b0);
        nolit.en = 1'b0;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0F, 7'h73, 7'h7F};

        rst = 1'b1; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0;
        rf_reg_data = 32'h0; rf_rd_valid = 1'b0; ex_ready = 1'b0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
        cur_need1 = 1'b0; cur_need2 = 1'b0; cur_rs1a = 5'd0; cur_rs2a = 5'd0;
        wb_random = 1'b0; fwd_script = 1'b0;
        step(); step();
        rst = 1'b0;

        check1("rst_if_ready", if_ready, 1'b1);
        check1("rst_rd_en", rf_rd_en, 1'b0);
        check("rst_rd_addr", 32'(rf_reg_addr), 32'h0);
        check1("rst_ex_valid", ex_valid, 1'b0);
        check("rst_ex_instr", ex_instr, 32'h0);
        check("rst_ex_pc", ex_pc, 32'h0);
        check("rst_ex_rs1", ex_rs1, 32'h0);
        check("rst_ex_rs2", ex_rs2, 32'h0);
        check("rst_ex_imm", ex_imm, 32'h0);
        check1("rst_ex_illegal", ex_illegal, 1'b0);

        // Directed cases with hand-computed results.
        run_txn(32'h002081B3, 32'h100, 3, 3, 0, 1'b1, 32'd5, 32'd7,
                mk_lit(8, 32'd5, 32'd7, 32'h0, 1'b0));
        run_txn(32'h123452B7, 32'h104, 3, 3, 0, 1'b0, 32'h0, 32'h0,
                mk_lit(1, 32'h0, 32'h0, 32'h12345000, 1'b0));
        run_txn(32'hFE000EE3, 32'h108, 3, 3, 0, 1'b0, 32'h0, 32'h0,
                mk_lit(1, 32'h0, 32'h0, 32'hFFFFFFFC, 1'b0));
        run_txn(32'hFFF00093, 32'h10C, 3, 3, 0, 1'b0, 32'h0, 32'h0,
                mk_lit(1, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0));
        fwd_script = 1'b1;
        run_txn(32'h002081B3, 32'h110, 3, 3, 2, 1'b1, 32'h11, 32'h44,
                mk_lit(8, 32'h22, 32'h33, 32'h0, 1'b0));
        fwd_script = 1'b0;
        run_txn(32'h002081B3, 32'h114, 3, 3, 5, 1'b1, 32'hAAAA_0001, 32'hBBBB_0002,
                mk_lit(8, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0, 1'b0));
        run_txn(32'h0000007F, 32'h118, 3, 3, 1, 1'b0, 32'h0, 32'h0,
                mk_lit(1, 32'h0, 32'h0, 32'h0, 1'b1));

        // Randomized instructions, latencies, back-pressure and writebacks.
        wb_random = 1'b1;
        for (int t = 0; t < 200; t++) begin
            r  = $urandom;
            op = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            ins = {r[31:7], op};
            if ($urandom_range(0, 4) == 0) ins[19:15] = 5'd0;
            if ($urandom_range(0, 4) == 0) ins[24:20] = 5'd0;
            run_txn(ins, $urandom, $urandom_range(1, 4), $urandom_range(1, 4),
                    $urandom_range(0, 3), 1'b0, 32'h0, 32'h0, nolit);
        end
        wb_random = 1'b0;

        // Reset while the second read is outstanding.
        cur_need1 = 1'b0; cur_need2 = 1'b0;
        if_valid = 1'b1; if_instr = 32'h002081B3; if_pc = 32'h200;
        step();
        if_valid = 1'b0;
        rf_rd_valid = 1'b0; step();
        rf_rd_valid = 1'b1; rf_reg_data = 32'h5; step();
        rf_rd_valid = 1'b0; step();
        check1("pre_rst_rd_en", rf_rd_en, 1'b1);
        check("pre_rst_rd_addr", 32'(rf_reg_addr), 32'd2);
        rst = 1'b1;
        step();
        check1("midrst_rd_en", rf_rd_en, 1'b0);
        check1("midrst_ex_valid", ex_valid, 1'b0);
        check1("midrst_if_ready", if_ready, 1'b1);
        check("midrst_ex_rs1", ex_rs1, 32'h0);
        check("midrst_ex_instr", ex_instr, 32'h0);
        rst = 1'b0;
        step();
        check1("midrst_hold_rd_en", rf_rd_en, 1'b0);
        run_txn(32'h002081B3, 32'h300, 2, 1, 0, 1'b1, 32'h9, 32'hA,
                mk_lit(5, 32'h9, 32'hA, 32'h0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
